// File: rtl/dmadd_seq.sv
// dmadd_seq: job sequencer for one DMADD delta/min/max datapath.
// Takes an op plus a stream of index/data load beats and drives DMADD
// through clear/init/load/run. It then returns the 8-bit result over
// a valid/ready handshake. Every output comes straight from a flop.
module dmadd_seq #(
  parameter int RUN_MAX = 24,
  parameter int CNT_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             abort,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_index,
  input  logic [3:0]       cmd_data,
  input  logic             cmd_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic             res_timeout,
  output logic             busy,
  output logic             dm_rst_n,
  output logic [1:0]       dm_insn,
  output logic             dm_load,
  output logic             dm_run,
  output logic [3:0]       dm_index,
  output logic [3:0]       dm_data,
  input  logic [7:0]       dm_out,
  input  logic [3:0]       dm_out_top
);

  // ABORT is a CLEAR that goes back to IDLE instead of on to INIT.
  // ISSUE is the cycle that drives the last beat, with cmd_ready already low.
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_INIT, S_LOAD, S_ISSUE, S_RUN, S_RESULT, S_ABORT
  } state_t;

  localparam logic [1:0] INSN_NOP = 2'b11;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       res_data_q, res_data_d;
  logic             res_timeout_q, res_timeout_d;
  logic [3:0]       dm_index_q, dm_index_d;
  logic [3:0]       dm_data_q, dm_data_d;
  logic             dm_rst_n_q, dm_rst_n_d;
  logic [1:0]       dm_insn_q, dm_insn_d;
  logic             dm_load_q, dm_load_d;
  logic             dm_run_q, dm_run_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             res_valid_q, res_valid_d;
  logic             busy_q, busy_d;
  logic             beat;
  logic [1:0]       init_code;

  // MIN initialises to 00; MAX and MADD both initialise with 01.
  assign init_code = (op_q == 2'b00) ? 2'b00 : 2'b01;

  // Next-state, beat capture, run counter and result capture.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    cnt_d         = cnt_q;
    res_data_d    = res_data_q;
    res_timeout_d = res_timeout_q;
    dm_index_d    = dm_index_q;
    dm_data_d     = dm_data_q;
    beat          = 1'b0;
    if (abort && state_q != S_IDLE) begin
      state_d = S_ABORT;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort && op != 2'b11) begin
            state_d = S_CLEAR;
            op_d    = op;
            cnt_d   = '0;
          end
        end
        S_CLEAR: state_d = S_INIT;
        S_INIT:  state_d = S_LOAD;
        S_LOAD: begin
          if (cmd_valid) begin
            beat       = 1'b1;
            dm_index_d = cmd_index;
            dm_data_d  = cmd_data;
            if (cmd_last) state_d = S_ISSUE;
          end
        end
        S_ISSUE: state_d = S_RUN;
        S_RUN: begin
          cnt_d = cnt_q + CNT_W'(1);
          // A datapath that stops on the same cycle as the limit still counts as done.
          if (dm_out_top == 4'd0) begin
            state_d       = S_RESULT;
            res_data_d    = dm_out;
            res_timeout_d = 1'b0;
          end else if (cnt_d == CNT_W'(RUN_MAX)) begin
            state_d       = S_RESULT;
            res_data_d    = dm_out;
            res_timeout_d = 1'b1;
          end
        end
        S_RESULT: if (res_ready) state_d = S_IDLE;
        S_ABORT:  state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Output decode from the state being entered, so pins line up with state.
  always_comb begin
    dm_rst_n_d  = 1'b1;
    dm_insn_d   = INSN_NOP;
    dm_load_d   = 1'b0;
    dm_run_d    = 1'b0;
    cmd_ready_d = 1'b0;
    res_valid_d = 1'b0;
    busy_d      = (state_d != S_IDLE);
    case (state_d)
      S_CLEAR, S_ABORT: dm_rst_n_d = 1'b0;
      S_INIT:           dm_insn_d  = init_code;
      S_LOAD, S_ISSUE: begin
        cmd_ready_d = (state_d == S_LOAD);
        dm_load_d   = beat;
        // Idle load cycles re-issue init, which leaves DMADD unchanged.
        dm_insn_d   = beat ? op_q : init_code;
      end
      S_RUN: begin
        dm_run_d  = 1'b1;
        dm_insn_d = op_q;
      end
      S_RESULT: res_valid_d = 1'b1;
      default: ;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      op_q          <= 2'b00;
      cnt_q         <= '0;
      res_data_q    <= 8'd0;
      res_timeout_q <= 1'b0;
      dm_index_q    <= 4'd0;
      dm_data_q     <= 4'd0;
      dm_rst_n_q    <= 1'b0;
      dm_insn_q     <= INSN_NOP;
      dm_load_q     <= 1'b0;
      dm_run_q      <= 1'b0;
      cmd_ready_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      cnt_q         <= cnt_d;
      res_data_q    <= res_data_d;
      res_timeout_q <= res_timeout_d;
      dm_index_q    <= dm_index_d;
      dm_data_q     <= dm_data_d;
      dm_rst_n_q    <= dm_rst_n_d;
      dm_insn_q     <= dm_insn_d;
      dm_load_q     <= dm_load_d;
      dm_run_q      <= dm_run_d;
      cmd_ready_q   <= cmd_ready_d;
      res_valid_q   <= res_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_timeout = res_timeout_q;
  assign busy        = busy_q;
  assign dm_rst_n    = dm_rst_n_q;
  assign dm_insn     = dm_insn_q;
  assign dm_load     = dm_load_q;
  assign dm_run      = dm_run_q;
  assign dm_index    = dm_index_q;
  assign dm_data     = dm_data_q;

endmodule

// File: tb/tb_dmadd_seq.sv
// Directed bench for dmadd_seq with a tiny DMADD stand-in that stops
// (dm_out_top=0) on a chosen RUN cycle, or never when done_at is 0.
module tb_dmadd_seq;
  logic       clk = 1'b0;
  logic       rst, start, abort, cmd_valid, cmd_last, res_ready;
  logic [1:0] op;
  logic [3:0] cmd_index, cmd_data;
  logic       cmd_ready, res_valid, res_timeout, busy;
  logic       dm_rst_n, dm_load, dm_run;
  logic [7:0] res_data, dm_out;
  logic [1:0] dm_insn;
  logic [3:0] dm_index, dm_data, dm_out_top;

  int n_tests = 0;
  int n_fail  = 0;
  int done_at = 0;
  int rc      = 0;
  int runs;
  logic [1:0] cur_op;

  dmadd_seq #(.RUN_MAX(24), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .abort(abort),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_index(cmd_index),
    .cmd_data(cmd_data), .cmd_last(cmd_last), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_timeout(res_timeout),
    .busy(busy), .dm_rst_n(dm_rst_n), .dm_insn(dm_insn), .dm_load(dm_load),
    .dm_run(dm_run), .dm_index(dm_index), .dm_data(dm_data),
    .dm_out(dm_out), .dm_out_top(dm_out_top)
  );

  always #5 clk = ~clk;

  // rc = number of RUN cycles already completed in the current run burst
  always @(posedge clk) rc <= dm_run ? rc + 1 : 0;
  assign dm_out_top = (done_at != 0 && rc == done_at - 1) ? 4'h0 : 4'hF;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_rstn",  32'(dm_rst_n), 0);   chk("rst_insn", 32'(dm_insn), 3);
    chk("rst_load",  32'(dm_load), 0);    chk("rst_run", 32'(dm_run), 0);
    chk("rst_index", 32'(dm_index), 0);   chk("rst_data", 32'(dm_data), 0);
    chk("rst_ready", 32'(cmd_ready), 0);  chk("rst_valid", 32'(res_valid), 0);
    chk("rst_res",   32'(res_data), 0);   chk("rst_tmo", 32'(res_timeout), 0);
    chk("rst_busy",  32'(busy), 0);
  endtask

  // start a job and walk CLEAR/INIT; returns at the first LOAD cycle
  task automatic begin_job(input logic [1:0] o);
    cur_op = o; start = 1'b1; op = o;
    @(negedge clk); start = 1'b0;
    chk("clear_rstn", 32'(dm_rst_n), 0); chk("clear_busy", 32'(busy), 1);
    @(negedge clk);
    chk("init_insn", 32'(dm_insn), (o == 2'b00) ? 0 : 1);
    chk("init_rstn", 32'(dm_rst_n), 1);
    @(negedge clk);
    chk("load_ready", 32'(cmd_ready), 1); chk("load_idle", 32'(dm_load), 0);
  endtask

  // present one beat for one cycle and check it is issued the next cycle
  task automatic beat(input logic [3:0] idx, input logic [3:0] dat, input logic lst);
    cmd_valid = 1'b1; cmd_index = idx; cmd_data = dat; cmd_last = lst;
    @(negedge clk); cmd_valid = 1'b0; cmd_last = 1'b0;
    chk("beat_load", 32'(dm_load), 1);   chk("beat_index", 32'(dm_index), 32'(idx));
    chk("beat_data", 32'(dm_data), 32'(dat)); chk("beat_insn", 32'(dm_insn), 32'(cur_op));
    chk("beat_ready", 32'(cmd_ready), lst ? 0 : 1);
  endtask

  task automatic idle_load();
    @(negedge clk);
    chk("gap_load", 32'(dm_load), 0);
    chk("gap_insn", 32'(dm_insn), (cur_op == 2'b00) ? 0 : 1);
  endtask

  // count RUN cycles until res_valid, bounded
  task automatic wait_result(output int nrun);
    bit got_it = 0;
    nrun = 0;
    for (int g = 0; g < 60 && !got_it; g++) begin
      @(negedge clk);
      if (res_valid) got_it = 1;
      else if (dm_run) begin
        nrun++;
        if (nrun == 1) chk("run_insn", 32'(dm_insn), 32'(cur_op));
      end
    end
    chk("result_seen", 32'(got_it), 1);
    chk("result_run_off", 32'(dm_run), 0);
    chk("result_insn", 32'(dm_insn), 3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; abort = 1'b0; cmd_valid = 1'b0;
    cmd_last = 1'b0; cmd_index = 4'd0; cmd_data = 4'd0; res_ready = 1'b1;
    dm_out = 8'd0; cur_op = 2'b00;
    repeat (2) @(negedge clk);
    chk_reset();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rstn", 32'(dm_rst_n), 1); chk("idle_busy", 32'(busy), 0);

    // MIN: one beat, datapath stops on the 6th RUN cycle
    done_at = 6; dm_out = 8'd5;
    begin_job(2'b00);
    beat(4'd5, 4'd0, 1'b1);
    wait_result(runs);
    chk("min_runs", 32'(runs), 6);
    chk("min_data", 32'(res_data), 5); chk("min_tmo", 32'(res_timeout), 0);
    @(negedge clk);
    chk("min_valid_drop", 32'(res_valid), 0); chk("min_idle", 32'(busy), 0);

    // MADD: three beats separated by idle load cycles
    done_at = 1; dm_out = 8'hA5;
    begin_job(2'b10);
    beat(4'd4, 4'd3, 1'b0);  idle_load();
    beat(4'd8, 4'd2, 1'b0);  idle_load();
    beat(4'd12, 4'd1, 1'b1);
    wait_result(runs);
    chk("madd_runs", 32'(runs), 1); chk("madd_data", 32'(res_data), 32'h A5);
    @(negedge clk);

    // Timeout, then hold the result under backpressure with start pushed
    done_at = 0; dm_out = 8'h3C; res_ready = 1'b0;
    begin_job(2'b01);
    beat(4'd1, 4'd0, 1'b1);
    wait_result(runs);
    chk("tmo_runs", 32'(runs), 24);
    chk("tmo_flag", 32'(res_timeout), 1); chk("tmo_data", 32'(res_data), 32'h3C);
    start = 1'b1; op = 2'b00; dm_out = 8'h00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(res_valid), 1); chk("bp_data", 32'(res_data), 32'h3C);
      chk("bp_tmo", 32'(res_timeout), 1); chk("bp_busy", 32'(busy), 1);
    end
    start = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 32'(res_valid), 0); chk("bp_idle", 32'(busy), 0);
    @(negedge clk);
    chk("bp_no_restart", 32'(busy), 0);

    // Abort in LOAD after two beats, then a clean MAX job
    begin_job(2'b00);
    beat(4'd2, 4'd0, 1'b0);
    beat(4'd3, 4'd0, 1'b0);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_rstn", 32'(dm_rst_n), 0); chk("abort_ready", 32'(cmd_ready), 0);
    @(negedge clk);
    chk("abort_idle", 32'(busy), 0); chk("abort_novalid", 32'(res_valid), 0);
    chk("abort_rstn_up", 32'(dm_rst_n), 1);
    done_at = 3; dm_out = 8'h77;
    begin_job(2'b01);
    beat(4'd9, 4'd0, 1'b1);
    wait_result(runs);
    chk("post_abort_runs", 32'(runs), 3);
    chk("post_abort_data", 32'(res_data), 32'h77); chk("post_abort_tmo", 32'(res_timeout), 0);
    @(negedge clk);

    // Reset in the middle of RUN
    done_at = 0;
    begin_job(2'b10);
    beat(4'd6, 4'd7, 1'b1);
    repeat (3) @(negedge clk);
    chk("pre_rst_run", 32'(dm_run), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 32'(busy), 0); chk("post_rst_rstn", 32'(dm_rst_n), 1);

    // abort+start together in IDLE, and reserved op
    start = 1'b1; abort = 1'b1; op = 2'b01;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("collide_busy", 32'(busy), 0); chk("collide_rstn", 32'(dm_rst_n), 1);
    start = 1'b1; op = 2'b11;
    @(negedge clk); start = 1'b0;
    chk("reserved_busy", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
